// File: rtl/debug_frame_serializer.sv
// debug_frame_serializer
// Captures a wide debug vector on request and streams it to uart_tx as a
// frame of bytes: header, data bytes LSB first, then the XOR of the data
// bytes. Each byte is handed over with a one-cycle tx_start pulse. The next
// byte is loaded only after uart_tx reports tx_done_tick for the current one.
module debug_frame_serializer #(
    parameter int         DATA_BITS = 1416,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] send_data,
    input  logic                 tx_done_tick,
    output logic                 tx_start,
    output logic [7:0]           tx_bus,
    output logic                 busy,
    output logic                 done
);

    localparam int NBYTES     = (DATA_BITS + 7) / 8;
    localparam int SHIFT_BITS = 8 * NBYTES;
    localparam int CNT_BITS   = $clog2(NBYTES + 1);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NBYTES);
    localparam logic [CNT_BITS-1:0] ONE_CNT  = CNT_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_DATA,
        PH_CHK
    } phase_t;

    state_t                 state_reg;
    phase_t                 phase_reg;
    logic [CNT_BITS-1:0]    count_reg;
    logic [7:0]             checksum_reg;
    logic [SHIFT_BITS-1:0]  shift_reg;
    logic [SHIFT_BITS-1:0]  capture_data;

    // Zero-extend the snapshot so unused bits of the last byte go out as 0.
    assign capture_data = SHIFT_BITS'(send_data);

    // Frame sequencer: all outputs are registered and come from this block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            phase_reg    <= PH_HDR;
            count_reg    <= '0;
            checksum_reg <= 8'h00;
            shift_reg    <= '0;
            tx_start     <= 1'b0;
            tx_bus       <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Both tx_start and done are single-cycle pulses.
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        shift_reg    <= capture_data;
                        checksum_reg <= 8'h00;
                        count_reg    <= '0;
                        busy         <= 1'b1;
                        tx_bus       <= HEADER;
                        phase_reg    <= PH_HDR;
                        state_reg    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_start  <= 1'b1;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // tx_bus stays untouched until uart_tx has finished the byte.
                    if (tx_done_tick) begin
                        case (phase_reg)
                            PH_HDR: begin
                                tx_bus       <= shift_reg[7:0];
                                checksum_reg <= shift_reg[7:0];
                                shift_reg    <= shift_reg >> 8;
                                count_reg    <= ONE_CNT;
                                phase_reg    <= PH_DATA;
                                state_reg    <= S_ISSUE;
                            end
                            PH_DATA: begin
                                if (count_reg != LAST_CNT) begin
                                    tx_bus       <= shift_reg[7:0];
                                    checksum_reg <= checksum_reg ^ shift_reg[7:0];
                                    shift_reg    <= shift_reg >> 8;
                                    count_reg    <= count_reg + ONE_CNT;
                                end else begin
                                    tx_bus    <= checksum_reg;
                                    phase_reg <= PH_CHK;
                                end
                                state_reg <= S_ISSUE;
                            end
                            default: begin
                                // Checksum byte done: done rises and busy drops together.
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                state_reg <= S_FINISH;
                            end
                        endcase
                    end
                end
                S_FINISH: begin
                    // One dead cycle, so a start coincident with done is ignored.
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
